// File: rtl/hog_regs_pkg.sv
// hog_regs_pkg: register map, bit positions, response codes and FSM states for the HOG control slave.
package hog_regs_pkg;
   localparam int C_DIM_WIDTH_DEF = 12;
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_WIDTH  = 2'd2;
   localparam logic [1:0] REG_HEIGHT = 2'd3;
   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int ST_BUSY     = 0;
   localparam int ST_DONE     = 1;
   localparam int ST_ERR      = 2;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/hog_axil_regs.sv
// hog_axil_regs: AXI4-Lite control/status slave feeding frame geometry and start to the HOG core.
module hog_axil_regs
   import hog_regs_pkg::*;
#(
   parameter int C_S_AXI_GP_DATA_WIDTH = 32,
   parameter int C_S_AXI_GP_ADDR_WIDTH = 4,
   parameter int C_DIM_WIDTH           = C_DIM_WIDTH_DEF
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [2:0]                       s_axi_awprot,
   input  logic                             s_axi_awvalid,
   output logic                             s_axi_awready,
   input  logic [C_S_AXI_GP_DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [3:0]                       s_axi_wstrb,
   input  logic                             s_axi_wvalid,
   output logic                             s_axi_wready,
   output logic [1:0]                       s_axi_bresp,
   output logic                             s_axi_bvalid,
   input  logic                             s_axi_bready,
   input  logic [C_S_AXI_GP_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [2:0]                       s_axi_arprot,
   input  logic                             s_axi_arvalid,
   output logic                             s_axi_arready,
   output logic [C_S_AXI_GP_DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]                       s_axi_rresp,
   output logic                             s_axi_rvalid,
   input  logic                             s_axi_rready,
   output logic [C_DIM_WIDTH-1:0]           cfg_width,
   output logic [C_DIM_WIDTH-1:0]           cfg_height,
   output logic                             cfg_start,
   input  logic                             core_busy,
   input  logic                             core_done,
   output logic                             irq
);
   localparam int DW = C_S_AXI_GP_DATA_WIDTH;

   w_state_t         w_state_q;
   r_state_t         r_state_q;
   logic             awready_q, wready_q, bvalid_q, aw_got_q, w_got_q;
   logic             arready_q, rvalid_q;
   logic [1:0]       aw_sel_q;
   logic [DW-1:0]    wdata_q, rdata_q, rd_mux, ctrl_rd, stat_rd, bm;
   logic [3:0]       wstrb_q;
   logic             irq_en_q, irq_en_d, done_q, done_d, err_q, err_d, cfg_start_q, cfg_start_d;
   logic [C_DIM_WIDTH-1:0] width_q, width_d, height_q, height_d;
   logic             aw_hs, w_hs, commit, wr_ctrl, wr_stat, start_wr, unused_ok;

   assign aw_hs  = s_axi_awvalid && awready_q;
   assign w_hs   = s_axi_wvalid && wready_q;
   assign commit = w_state_q == W_COMMIT;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         aw_sel_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_sel_q <= s_axi_awaddr[3:2];
                  aw_got_q <= 1'b1;
               end
               if (w_hs) begin
                  wdata_q <= s_axi_wdata;
                  wstrb_q <= s_axi_wstrb;
                  w_got_q <= 1'b1;
               end
               awready_q <= !(aw_got_q || aw_hs);
               wready_q  <= !(w_got_q || w_hs);
               if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) w_state_q <= W_COMMIT;
            end
            W_COMMIT: begin
               bvalid_q  <= 1'b1;
               aw_got_q  <= 1'b0;
               w_got_q   <= 1'b0;
               w_state_q <= W_RESP;
            end
            W_RESP:
               if (s_axi_bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  w_state_q <= W_IDLE;
               end
            default: w_state_q <= W_IDLE;
         endcase
      end

   // Read data is captured from pre-commit register state, so a same-cycle write is not visible yet.
   always_comb begin
      ctrl_rd = '0;
      ctrl_rd[CTRL_IRQ_EN] = irq_en_q;
      stat_rd = '0;
      stat_rd[ST_BUSY] = core_busy;
      stat_rd[ST_DONE] = done_q;
      stat_rd[ST_ERR]  = err_q;
      rd_mux = s_axi_araddr[3:2] == REG_CTRL   ? ctrl_rd :
               s_axi_araddr[3:2] == REG_STATUS ? stat_rd :
               s_axi_araddr[3:2] == REG_WIDTH  ? DW'(width_q) : DW'(height_q);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else if (r_state_q == R_IDLE) begin
         if (s_axi_arvalid && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_mux;
            r_state_q <= R_DATA;
         end else arready_q <= 1'b1;
      end else if (s_axi_rready) begin
         rvalid_q  <= 1'b0;
         arready_q <= 1'b1;
         r_state_q <= R_IDLE;
      end

   always_comb begin
      for (int i = 0; i < DW / 8; i++) bm[8*i +: 8] = {8{wstrb_q[i]}};
      wr_ctrl     = commit && aw_sel_q == REG_CTRL && wstrb_q[0];
      wr_stat     = commit && aw_sel_q == REG_STATUS && wstrb_q[0];
      start_wr    = wr_ctrl && wdata_q[CTRL_START];
      irq_en_d    = wr_ctrl ? wdata_q[CTRL_IRQ_EN] : irq_en_q;
      cfg_start_d = start_wr && !core_busy;
      err_d       = (err_q && !(wr_stat && wdata_q[ST_ERR])) || (start_wr && core_busy);
      // A completion pulse coinciding with a DONE clear must not be lost.
      done_d      = (done_q && !(wr_stat && wdata_q[ST_DONE])) || core_done;
      width_d     = commit && aw_sel_q == REG_WIDTH ?
                    (width_q & ~bm[C_DIM_WIDTH-1:0]) | (wdata_q[C_DIM_WIDTH-1:0] & bm[C_DIM_WIDTH-1:0]) : width_q;
      height_d    = commit && aw_sel_q == REG_HEIGHT ?
                    (height_q & ~bm[C_DIM_WIDTH-1:0]) | (wdata_q[C_DIM_WIDTH-1:0] & bm[C_DIM_WIDTH-1:0]) : height_q;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cfg_start_q <= 1'b0;
         width_q     <= '0;
         height_q    <= '0;
      end else begin
         irq_en_q    <= irq_en_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cfg_start_q <= cfg_start_d;
         width_q     <= width_d;
         height_q    <= height_d;
      end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = RESP_OKAY;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = RESP_OKAY;
   assign cfg_width     = width_q;
   assign cfg_height    = height_q;
   assign cfg_start     = cfg_start_q;
   assign irq           = irq_en_q && done_q;
   assign unused_ok     = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0],
                            wdata_q[DW-1:C_DIM_WIDTH], bm[DW-1:C_DIM_WIDTH]};
endmodule
